wb_merge: RTL and testbench

- Write-back merge stage directly upstream of the register file. It drives the register file's write enable, write address and write data.
- Three result sources feed it:
  - ALU pipeline: one cycle, no backpressure.
  - Load/store unit: valid/ready handshake, raw load word.
  - Multi-cycle mul/div unit: valid/ready handshake.
- Each cycle it picks at most one source, aligns and extends load data, and suppresses writes to x0. The register file physically allows x0 to be written, so this stage keeps x0 at zero.
- It bounds LSU/MDU starvation by stalling the ALU.

---
 rtl/wb_merge.sv | 143 ++++++++++++++
 tb/tb_wb_merge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// Write-back merge: picks ALU, LSU or MDU result each cycle,
// aligns load data, keeps x0 at zero and bounds LSU/MDU starvation.
module wb_merge #(
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wen,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_addr_lo,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        rf_wen,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_din
);

  typedef enum logic {
    PTR_LSU = 1'b0,
    PTR_MDU = 1'b1
  } rr_t;

  rr_t         rr_ptr, rr_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        alu_win, lsu_gnt, mdu_gnt, any_win;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Stall is decoded from the counter alone so it never loops
  // back through the requesters' inputs.
  assign alu_stall = (wait_cnt == 4'(STALL_LIMIT));
  assign alu_win   = alu_wen & ~alu_stall;

  // Grant: unstalled ALU first, then round-robin LSU/MDU.
  always_comb begin
    lsu_gnt = 1'b0;
    mdu_gnt = 1'b0;
    if (!alu_win) begin
      if (lsu_valid && mdu_valid) begin
        lsu_gnt = (rr_ptr == PTR_LSU);
        mdu_gnt = (rr_ptr == PTR_MDU);
      end else begin
        lsu_gnt = lsu_valid;
        mdu_gnt = mdu_valid;
      end
    end
  end

  // No handshake may complete while reset is held.
  assign lsu_ready = lsu_gnt & rst_n;
  assign mdu_ready = mdu_gnt & rst_n;
  assign any_win   = alu_win | lsu_gnt | mdu_gnt;

  // Load alignment and sign/zero extension.
  always_comb begin
    ld_shift = lsu_data >> {lsu_addr_lo, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = lsu_addr_lo[1] ? lsu_data[31:16]
                              : lsu_data[15:0];
    case (lsu_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = lsu_data;
    endcase
  end

  // Winner's destination and data.
  always_comb begin
    win_rd   = 5'd0;
    win_data = 32'h0;
    unique case (1'b1)
      alu_win: begin
        win_rd   = alu_rd;
        win_data = alu_data;
      end
      lsu_gnt: begin
        win_rd   = lsu_rd;
        win_data = ld_data;
      end
      mdu_gnt: begin
        win_rd   = mdu_rd;
        win_data = mdu_data;
      end
      default: ;
    endcase
  end

  // Next round-robin pointer and starvation count.
  always_comb begin
    rr_nxt   = rr_ptr;
    wait_nxt = wait_cnt;
    if (lsu_gnt)
      rr_nxt = PTR_MDU;
    else if (mdu_gnt)
      rr_nxt = PTR_LSU;
    if (lsu_gnt || mdu_gnt || !(lsu_valid || mdu_valid))
      wait_nxt = 4'd0;
    else if (wait_cnt != 4'hF)
      wait_nxt = wait_cnt + 4'd1;
  end

  // Arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= PTR_LSU;
      wait_cnt <= 4'd0;
    end else begin
      rr_ptr   <= rr_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Register-file write port; x0 writes are dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_addr <= 5'd0;
      rf_din  <= 32'h0;
    end else begin
      rf_wen <= any_win && (win_rd != 5'd0);
      if (any_win) begin
        rf_addr <= win_rd;
        rf_din  <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: ALU path, x0, load extension,
// round-robin, starvation stall and async reset.
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wen;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_din;

  int checks = 0;
  int errors = 0;

  wb_merge #(.STALL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wen(alu_wen), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_din(rf_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wen   = 1'b0;
    lsu_valid = 1'b0;
    mdu_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001,
                              3'b101, 3'b010};
  logic [1:0]  ld_lo  [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF81, 32'h0000_0080,
                              32'hFFFF_80F0, 32'h0000_7F81,
                              32'h80F0_7F81};

  initial begin
    rst_n = 1'b0;
    idle();
    alu_rd = 5'd0; alu_data = 32'h0;
    lsu_rd = 5'd0; lsu_data = 32'h0;
    lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
    mdu_rd = 5'd0; mdu_data = 32'h0;

    // reset state
    step();
    lsu_valid = 1'b1;
    mdu_valid = 1'b1;
    #1;
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_mdu_ready", mdu_ready, 0);
    step();
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_din", rf_din, 0);
    chk("rst_stall", alu_stall, 0);
    idle();
    rst_n = 1'b1;
    #1;

    // ALU only
    alu_wen = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    chk("alu_stall0", alu_stall, 0);
    chk("alu_lsu_rdy", lsu_ready, 0);
    step();
    idle();
    chk("alu_wen", rf_wen, 1);
    chk("alu_addr", rf_addr, 5);
    chk("alu_din", rf_din, 32'h1234);
    step();
    chk("alu_idle_wen", rf_wen, 0);
    chk("alu_hold_addr", rf_addr, 5);

    // x0 suppression
    alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    step();
    idle();
    chk("x0_alu_wen", rf_wen, 0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    #1;
    chk("x0_lsu_rdy", lsu_ready, 1);
    step();
    idle();
    chk("x0_lsu_wen", rf_wen, 0);

    // load extension
    lsu_data = 32'h80F0_7F81;
    lsu_rd   = 5'd7;
    for (int i = 0; i < 5; i++) begin
      lsu_valid   = 1'b1;
      lsu_funct3  = ld_f3[i];
      lsu_addr_lo = ld_lo[i];
      #1;
      chk($sformatf("ld%0d_rdy", i), lsu_ready, 1);
      step();
      idle();
      chk($sformatf("ld%0d_wen", i), rf_wen, 1);
      chk($sformatf("ld%0d_din", i), rf_din, ld_exp[i]);
    end

    // round-robin after reset
    do_reset();
    lsu_funct3 = 3'b010; lsu_data = 32'hAAAA_0001;
    lsu_rd = 5'd10; mdu_rd = 5'd20; mdu_data = 32'hBBBB_0002;
    lsu_valid = 1'b1; mdu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_lsu", i), lsu_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_mdu", i), mdu_ready, (i % 2 == 1));
      step();
      chk($sformatf("rr%0d_addr", i), rf_addr,
          (i % 2 == 0) ? 32'd10 : 32'd20);
    end
    idle();
    step();

    // starvation with STALL_LIMIT=4
    alu_wen = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("sv%0d_stall", i), alu_stall, 0);
      chk($sformatf("sv%0d_mdu", i), mdu_ready, 0);
      step();
      chk($sformatf("sv%0d_addr", i), rf_addr, 3);
    end
    #1;
    chk("sv4_stall", alu_stall, 1);
    chk("sv4_mdu", mdu_ready, 1);
    step();
    chk("sv4_addr", rf_addr, 9);
    chk("sv4_din", rf_din, 32'h99);
    chk("sv5_stall", alu_stall, 0);
    chk("sv5_mdu", mdu_ready, 0);
    idle();
    step();

    // async reset mid-stream; LSU grant first leaves ptr on MDU
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hABCD;
    step();
    lsu_valid = 1'b0;
    chk("ar_pre_wen", rf_wen, 1);
    chk("ar_pre_addr", rf_addr, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wen", rf_wen, 0);
    chk("ar_addr", rf_addr, 0);
    chk("ar_din", rf_din, 0);
    lsu_rd = 5'd10;
    lsu_valid = 1'b1; mdu_valid = 1'b1;
    #1;
    chk("ar_lsu_rdy", lsu_ready, 0);
    chk("ar_mdu_rdy", mdu_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("ar_rel_lsu", lsu_ready, 1);
    chk("ar_rel_mdu", mdu_ready, 0);
    step();
    chk("ar_rel_addr", rf_addr, 10);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
